// File: rtl/conv_pkg.sv
// Shared constants and helpers for the BCD/binary converters in the conv library.
package conv_pkg;

  localparam int BCD_DIGIT_BITS    = 4;
  localparam int BCD_MAX_DIGIT     = 9;
  localparam int REV_DABBLE_THRESH = 8;
  localparam int REV_DABBLE_CORR   = 3;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_BITS-1:0] digit);
    return digit <= BCD_DIGIT_BITS'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble: shift right, then -3 on digits >= 8).
// Validates every digit first; a nonzero BCD residue after the last shift flags overflow.
module bcd_to_bin
  import conv_pkg::*;
#(
  parameter int IN_BITS  = 3*4,
  parameter int OUT_BITS = 8
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic [IN_BITS-1:0]  in_bcd,
  output logic [OUT_BITS-1:0] out_num,
  output logic                out_error,
  output logic                out_finished
);

  localparam int NUM_BCD_DIGITS = IN_BITS / BCD_DIGIT_BITS;
  localparam int BIT_W = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam int DIG_W = (NUM_BCD_DIGITS > 1) ? $clog2(NUM_BCD_DIGITS) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OUT_BITS - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_BCD_DIGITS - 1);

  typedef enum logic [2:0] {Idle, Check, Shift, Sub, NextIndex, Final} t_state;

  t_state                    state;
  logic [IN_BITS-1:0]        bcd;
  logic [OUT_BITS-1:0]       bin;
  logic [BIT_W-1:0]          bit_idx;
  logic [DIG_W-1:0]          dig_idx;
  logic [BCD_DIGIT_BITS-1:0] digit;

  // Both Check and Sub walk the same digit index, so one mux serves them.
  assign digit        = bcd[dig_idx*BCD_DIGIT_BITS +: BCD_DIGIT_BITS];
  assign out_finished = (state == Idle);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state     <= Idle;
      out_num   <= '0;
      out_error <= 1'b0;
      bcd       <= '0;
      bin       <= '0;
      bit_idx   <= BIT_LAST;
      dig_idx   <= DIG_LAST;
    end else begin
      case (state)
        Idle: begin
          if (in_start) begin
            bcd       <= in_bcd;
            bin       <= '0;
            bit_idx   <= BIT_LAST;
            dig_idx   <= DIG_LAST;
            out_error <= 1'b0;
            state     <= Check;
          end
        end
        Check: begin
          if (!bcd_digit_valid(digit)) begin
            out_error <= 1'b1;
            out_num   <= '0;
            state     <= Idle;
          end else if (dig_idx == '0) begin
            dig_idx <= DIG_LAST;
            state   <= Shift;
          end else begin
            dig_idx <= dig_idx - DIG_W'(1);
          end
        end
        Shift: begin
          {bcd, bin} <= {1'b0, bcd, bin[OUT_BITS-1:1]};
          state      <= (bit_idx != '0) ? Sub : Final;
        end
        Sub: begin
          if (digit >= BCD_DIGIT_BITS'(REV_DABBLE_THRESH))
            bcd[dig_idx*BCD_DIGIT_BITS +: BCD_DIGIT_BITS] <= digit - BCD_DIGIT_BITS'(REV_DABBLE_CORR);
          if (dig_idx == '0) begin
            dig_idx <= DIG_LAST;
            state   <= NextIndex;
          end else begin
            dig_idx <= dig_idx - DIG_W'(1);
          end
        end
        NextIndex: begin
          bit_idx <= bit_idx - BIT_W'(1);
          state   <= Shift;
        end
        Final: begin
          // Whatever is left in the BCD register is the part of the value above 2^OUT_BITS.
          out_num   <= bin;
          out_error <= (bcd != '0);
          state     <= Idle;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed, table-driven bench for bcd_to_bin with reset-abort and round-trip sequences.
module tb_bcd_to_bin;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_start = 1'b0;
  logic [11:0] in_bcd = '0;
  logic [7:0]  out_num;
  logic        out_error;
  logic        out_finished;

  int vectors = 0;
  int miscompares = 0;

  bcd_to_bin #(.IN_BITS(12), .OUT_BITS(8)) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_start(in_start),
    .in_bcd(in_bcd),
    .out_num(out_num),
    .out_error(out_error),
    .out_finished(out_finished)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [11:0] bcd;
    logic [7:0]  num;
    logic        err;
    int          busy;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Pulse start, scramble in_bcd afterwards, and count negedges with out_finished low.
  task automatic run_conv(input logic [11:0] bcd, output int busy);
    @(negedge in_clk);
    in_bcd   = bcd;
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
    in_bcd   = 12'hFFF;
    busy = 0;
    while (!out_finished && busy < 200) begin
      busy++;
      @(negedge in_clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy;

    tbl[0] = '{12'h255, 8'hFF, 1'b0, 40};
    tbl[1] = '{12'h000, 8'h00, 1'b0, 40};
    tbl[2] = '{12'h999, 8'hE7, 1'b1, 40};
    tbl[3] = '{12'h2A5, 8'h00, 1'b1, 2};
    tbl[4] = '{12'h100, 8'h64, 1'b0, 40};
    tbl[5] = '{12'h09F, 8'h00, 1'b1, 3};
    tbl[6] = '{12'h087, 8'h57, 1'b0, 40};
    tbl[7] = '{12'hA00, 8'h00, 1'b1, 1};
    tbl[8] = '{12'h256, 8'h00, 1'b1, 40};
    tbl[9] = '{12'h128, 8'h80, 1'b0, 40};

    repeat (3) @(negedge in_clk);
    in_rst = 1'b0;
    check("reset finished", out_finished, 1);
    check("reset num", out_num, 0);
    check("reset error", out_error, 0);

    for (int i = 0; i < 10; i++) begin
      run_conv(tbl[i].bcd, busy);
      check($sformatf("busy[%0d]", i), busy, tbl[i].busy);
      check($sformatf("num[%0d]", i), out_num, tbl[i].num);
      check($sformatf("error[%0d]", i), out_error, tbl[i].err);
    end

    // Reset mid-conversion after a successful 0x128, with an ignored start during busy.
    @(negedge in_clk);
    in_bcd   = 12'h042;
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) in_start = 1'b1;
      if (c == 6) in_start = 1'b0;
      check($sformatf("abort busy c%0d", c), out_finished, 0);
      if (c < 10) @(negedge in_clk);
    end
    check("abort num before rst", out_num, 8'h80);
    in_rst = 1'b1;
    @(negedge in_clk);
    in_rst = 1'b0;
    check("abort finished", out_finished, 1);
    check("abort num", out_num, 0);
    check("abort error", out_error, 0);

    // Round trip with start held high: each conversion must take 40 cycles after one Idle cycle.
    @(negedge in_clk);
    in_bcd   = to_bcd(0);
    in_start = 1'b1;
    for (int n = 0; n < 256; n++) begin
      busy = 0;
      do begin
        @(negedge in_clk);
        busy++;
      end while (!out_finished && busy < 100);
      if (n < 255) in_bcd = to_bcd(n + 1);
      else in_start = 1'b0;
      check($sformatf("rt busy %0d", n), busy - 1, 40);
      check($sformatf("rt num %0d", n), out_num, n);
      check($sformatf("rt error %0d", n), out_error, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
